// File: rtl/simon_key_expander_if.sv
`default_nettype none
// ============================================================================
// simon_key_expander_if : key-load / round-key handshake bundle for the
//                         Simon key-schedule engine (rd_* under KS_STORE_EN)
// Rev 1.0
// ============================================================================
interface simon_key_expander_if #(
  parameter int N = 48,
  parameter int M = 2
);
  logic           start;
  logic [N*M-1:0] key_in;
  logic           rk_ready;
  logic           rk_valid;
  logic [N-1:0]   rk_data;
  logic [6:0]     rk_idx;
  logic           busy;
  logic           done;
`ifdef KS_STORE_EN
  logic [6:0]     rd_addr;
  logic [N-1:0]   rd_data;

  modport master (
    output start, key_in, rk_ready, rd_addr,
    input  rk_valid, rk_data, rk_idx, busy, done, rd_data
  );
  modport slave (
    input  start, key_in, rk_ready, rd_addr,
    output rk_valid, rk_data, rk_idx, busy, done, rd_data
  );
`else
  modport master (
    output start, key_in, rk_ready,
    input  rk_valid, rk_data, rk_idx, busy, done
  );
  modport slave (
    input  start, key_in, rk_ready,
    output rk_valid, rk_data, rk_idx, busy, done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/simon_key_expander.sv
`default_nettype none
// ============================================================================
// simon_key_expander : sequential Simon key schedule, one round key per
//                      valid/ready handshake. Optional KS_STORE_EN keeps a
//                      readable T x N copy of every accepted key.
// Rev 1.0
// ============================================================================
module simon_key_expander #(
  parameter int N     = 48,
  parameter int M     = 2,
  parameter int T     = 52,
  parameter int Z_SEL = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  simon_key_expander_if.slave   bus
);

  // Leftmost character of each sequence is z bit 0, held here in the MSB.
  localparam logic [61:0] C_Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] C_Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] C_Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] C_Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] C_Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
  localparam logic [61:0] C_Z  = (Z_SEL == 0) ? C_Z0 :
                                 (Z_SEL == 1) ? C_Z1 :
                                 (Z_SEL == 2) ? C_Z2 :
                                 (Z_SEL == 3) ? C_Z3 : C_Z4;
  localparam logic [6:0]  C_LAST = 7'(T - 1);

  if (!(N == 16 || N == 24 || N == 32 || N == 48 || N == 64)) begin : g_bad_n
    $error("simon_key_expander: unsupported N=%0d", N);
  end
  if (M < 2 || M > 4) begin : g_bad_m
    $error("simon_key_expander: unsupported M=%0d", M);
  end
  if (T < 1 || T > 127) begin : g_bad_t
    $error("simon_key_expander: unsupported T=%0d", T);
  end
  if (Z_SEL < 0 || Z_SEL > 4) begin : g_bad_z
    $error("simon_key_expander: unsupported Z_SEL=%0d", Z_SEL);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [M-1:0][N-1:0] win;
  logic [6:0]          idx;
  logic [5:0]          zc;
  logic                hs;
  logic                last;
  logic                load;
  logic                zbit;
  logic [N-1:0]        rot3;
  logic [N-1:0]        mix;
  logic [N-1:0]        knew;

  assign hs   = (state == S_RUN) & bus.rk_ready;
  assign last = (idx == C_LAST);
  assign load = (state == S_IDLE) & bus.start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN:   if (bus.rk_ready && last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // w[M-1] is the newest key; ROR3 of it, plus w[1] for four-word keys.
  assign rot3 = {win[M-1][2:0], win[M-1][N-1:3]};

  if (M == 4) begin : g_m4
    assign mix = rot3 ^ win[1];
  end else begin : g_m23
    assign mix = rot3;
  end

  assign zbit = C_Z[6'd61 - zc];
  assign knew = ~win[0] ^ mix ^ {mix[0], mix[N-1:1]}
              ^ {{(N-1){1'b0}}, zbit} ^ {{(N-2){1'b0}}, 2'b11};

  always_ff @(posedge clk) begin
    if (rst) begin
      win <= '0;
      idx <= '0;
      zc  <= '0;
    end else if (load) begin
      win <= bus.key_in;
      idx <= '0;
      zc  <= '0;
    end else if (hs && !last) begin
      for (int j = 0; j < M - 1; j++) begin
        win[j] <= win[j+1];
      end
      win[M-1] <= knew;
      idx      <= idx + 7'd1;
      zc       <= (zc == 6'd61) ? 6'd0 : zc + 6'd1;
    end
  end

  assign bus.rk_valid = (state == S_RUN);
  assign bus.rk_data  = win[0];
  assign bus.rk_idx   = idx;
  assign bus.busy     = (state == S_RUN);
  assign bus.done     = (state == S_DONE);

`ifdef KS_STORE_EN
  logic [N-1:0] store [T];
  logic [N-1:0] rd_sel;
  logic [N-1:0] rd_q;

  // Addresses at or beyond T match no entry and therefore read zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < T; i++) begin
      if (bus.rd_addr == 7'(i)) rd_sel = store[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < T; i++) begin
        store[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      for (int i = 0; i < T; i++) begin
        if (hs && idx == 7'(i)) store[i] <= win[0];
      end
      rd_q <= rd_sel;
    end
  end

  assign bus.rd_data = rd_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_simon_key_expander.sv
`default_nettype none
// ============================================================================
// tb_simon_key_expander : directed bench for three key-schedule configurations
// Rev 1.0
// ============================================================================
module tb_simon_key_expander;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simon_key_expander_if #(.N(16), .M(4)) bus_a ();
  simon_key_expander_if #(.N(64), .M(4)) bus_b ();
  simon_key_expander_if #(.N(48), .M(2)) bus_c ();

  simon_key_expander #(.N(16), .M(4), .T(32), .Z_SEL(0)) u_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave));
  simon_key_expander #(.N(64), .M(4), .T(72), .Z_SEL(4)) u_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave));
  simon_key_expander u_c (
    .clk (clk), .rst (rst), .bus (bus_c.slave));

  int n_checks = 0;
  int n_errors = 0;

  string zs [5] = '{
    "11111010001001010110000111001101111101000100101011000011100110",
    "10001110111110010011000010110101000111011111001001100001011010",
    "10101111011100000011010010011000101000010001111110010110110011",
    "11011011101011000110010111100000010010001010011100110100001111",
    "11010001111001101011011000100000010111000011001010010011101111"
  };

  logic [63:0] mdl [0:135];
  logic [63:0] obs [0:135];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rorn(input logic [63:0] x, input int r, input int n);
    logic [63:0] mask;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    return ((x >> r) | (x << (n - r))) & mask;
  endfunction

  task automatic build_model(input int n, input int m, input int zsel,
                             input logic [255:0] key, input int t);
    logic [63:0] mask;
    logic [63:0] tmp;
    logic [255:0] kk;
    logic [7:0] ch;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    kk = key;
    for (int j = 0; j < m; j++) begin
      mdl[j] = kk[63:0] & mask;
      kk = kk >> n;
    end
    for (int i = m; i < t; i++) begin
      tmp = rorn(mdl[i-1], 3, n);
      if (m == 4) tmp = tmp ^ mdl[i-3];
      tmp = tmp ^ rorn(tmp, 1, n);
      ch = zs[zsel][(i - m) % 62];
      mdl[i] = (~mdl[i-m] ^ tmp ^ {63'd0, ch == "1"} ^ 64'd3) & mask;
    end
  endtask

  // Streams one full schedule from DUT A, optionally with random back-pressure
  // and with start poked mid-run and in the DONE cycle.
  task automatic run_a(input logic [63:0] key, input bit rnd, input bit poke);
    int e;
    int cyc;
    build_model(16, 4, 0, {192'd0, key}, 32);
    bus_a.key_in = key;
    bus_a.start  = 1'b1;
    tick();
    bus_a.start = 1'b0;
    e = 0;
    cyc = 0;
    while (e < 32 && cyc < 1000) begin
      check("a_valid", {63'd0, bus_a.rk_valid}, 64'd1);
      check("a_busy", {63'd0, bus_a.busy}, 64'd1);
      check("a_done_low", {63'd0, bus_a.done}, 64'd0);
      check("a_idx", {57'd0, bus_a.rk_idx}, 64'(e));
      check("a_data", {48'd0, bus_a.rk_data}, mdl[e]);
      obs[e] = {48'd0, bus_a.rk_data};
      bus_a.rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) bus_a.start = (cyc == 5);
      if (bus_a.rk_ready) e++;
      tick();
      cyc++;
    end
    bus_a.rk_ready = 1'b0;
    check("a_no_timeout", {63'd0, cyc < 1000}, 64'd1);
    check("a_done_pulse", {63'd0, bus_a.done}, 64'd1);
    check("a_valid_drop", {63'd0, bus_a.rk_valid}, 64'd0);
    if (poke) bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    check("a_done_end", {63'd0, bus_a.done}, 64'd0);
    check("a_idle_busy", {63'd0, bus_a.busy}, 64'd0);
    tick();
    check("a_still_idle", {63'd0, bus_a.rk_valid}, 64'd0);
  endtask

  task automatic run_b(input logic [255:0] key);
    int e;
    int cyc;
    build_model(64, 4, 4, key, 72);
    bus_b.key_in   = key;
    bus_b.rk_ready = 1'b1;
    bus_b.start    = 1'b1;
    tick();
    bus_b.start = 1'b0;
    e = 0;
    cyc = 0;
    while (e < 72 && cyc < 200) begin
      if (bus_b.rk_valid) begin
        check("b_idx", {57'd0, bus_b.rk_idx}, 64'(e));
        check("b_data", bus_b.rk_data, mdl[e]);
        e++;
      end
      tick();
      cyc++;
    end
    check("b_done", {63'd0, bus_b.done}, 64'd1);
    tick();
    check("b_done_end", {63'd0, bus_b.done}, 64'd0);
  endtask

  task automatic run_c(input logic [95:0] key);
    int e;
    int cyc;
    build_model(48, 2, 2, {160'd0, key}, 52);
    bus_c.key_in   = key;
    bus_c.rk_ready = 1'b1;
    bus_c.start    = 1'b1;
    tick();
    bus_c.start = 1'b0;
    e = 0;
    cyc = 0;
    while (e < 52 && cyc < 200) begin
      if (bus_c.rk_valid) begin
        check("c_idx", {57'd0, bus_c.rk_idx}, 64'(e));
        check("c_data", {16'd0, bus_c.rk_data}, mdl[e]);
        e++;
      end
      tick();
      cyc++;
    end
    check("c_done", {63'd0, bus_c.done}, 64'd1);
    tick();
    check("c_done_end", {63'd0, bus_c.done}, 64'd0);
  endtask

  initial begin
    logic [63:0] key1;
    key1 = 64'h1918_1110_0908_0100;
    bus_a.start = 1'b0; bus_a.key_in = '0; bus_a.rk_ready = 1'b0;
    bus_b.start = 1'b0; bus_b.key_in = '0; bus_b.rk_ready = 1'b0;
    bus_c.start = 1'b0; bus_c.key_in = '0; bus_c.rk_ready = 1'b0;
`ifdef KS_STORE_EN
    bus_a.rd_addr = '0; bus_b.rd_addr = '0; bus_c.rd_addr = '0;
`endif
    rst = 1'b1;
    tick();
    tick();
    check("rst_valid", {63'd0, bus_a.rk_valid}, 64'd0);
    check("rst_data", {48'd0, bus_a.rk_data}, 64'd0);
    check("rst_idx", {57'd0, bus_a.rk_idx}, 64'd0);
    check("rst_busy", {63'd0, bus_a.busy}, 64'd0);
    check("rst_done", {63'd0, bus_a.done}, 64'd0);
    rst = 1'b0;
    tick();

    // Published Simon32/64 key: first five round keys known by hand.
    run_a(key1, 1'b0, 1'b0);
    check("hand_k0", obs[0], 64'h0100);
    check("hand_k1", obs[1], 64'h0908);
    check("hand_k2", obs[2], 64'h1110);
    check("hand_k3", obs[3], 64'h1918);
    check("hand_k4", obs[4], 64'h71C3);

`ifdef KS_STORE_EN
    for (int a = 0; a < 32; a++) begin
      bus_a.rd_addr = 7'(a);
      tick();
      check("store_rd", {48'd0, bus_a.rd_data}, mdl[a]);
    end
    bus_a.rd_addr = 7'd32;
    tick();
    check("store_oob", {48'd0, bus_a.rd_data}, 64'd0);
`endif

    run_a(key1, 1'b1, 1'b0);
    run_a(64'hA5C3_3C5A_0F0F_F00F, 1'b1, 1'b0);

    // Reset mid-run, with start asserted in the same cycle.
    bus_a.key_in   = key1;
    bus_a.rk_ready = 1'b1;
    bus_a.start    = 1'b1;
    tick();
    bus_a.start = 1'b0;
    repeat (10) tick();
    check("mid_idx", {57'd0, bus_a.rk_idx}, 64'd10);
    rst = 1'b1;
    bus_a.start = 1'b1;
    tick();
    check("mrst_valid", {63'd0, bus_a.rk_valid}, 64'd0);
    check("mrst_data", {48'd0, bus_a.rk_data}, 64'd0);
    check("mrst_idx", {57'd0, bus_a.rk_idx}, 64'd0);
    check("mrst_busy", {63'd0, bus_a.busy}, 64'd0);
    check("mrst_done", {63'd0, bus_a.done}, 64'd0);
    rst = 1'b0;
    bus_a.start = 1'b0;
    bus_a.rk_ready = 1'b0;
    tick();
    check("mrst_idle", {63'd0, bus_a.rk_valid}, 64'd0);
    run_a(key1, 1'b0, 1'b0);

    run_a(key1, 1'b1, 1'b1);

    run_b({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    for (int k = 0; k < 4; k++) begin
      run_c({$urandom, $urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
